// File: rtl/serial_cell_der_a_izq.sv
// Bit-serial magnitude comparator. Operand pairs (x,y) arrive MSB first, one per
// bit_valid/bit_ready handshake. The initial, typical and final cells of the
// iterative comparator are folded into a single four-state FSM. {A,B} selects
// the result: 00 equal, 01 greater, 10 less, 11 greater-or-equal.
// Optional feature: define SERIAL_CELL_EARLY_DECIDE_EN to end the operation at
// the first differing pair instead of always consuming all N pairs.
module serial_cell_der_a_izq #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          A,
  input  logic          B,
  input  logic          x,
  input  logic          y,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic          busy,
  output logic [CW-1:0] idx,
  output logic          f,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StFinal} state_e;

  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  state_e        state_q, state_d;
  logic          a_q, a_d, b_q, b_d;
  logic          eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          f_q, f_d;
  logic          done_q, done_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      eq_q    <= 1'b1;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      idx_q   <= '0;
      f_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      idx_q   <= idx_d;
      f_q     <= f_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: one cell evaluation per accepted pair.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    idx_d   = idx_q;
    f_d     = f_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = StInit;
        end
      end
      StInit: begin
        eq_d    = 1'b1;
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        idx_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (bit_valid) begin
          idx_d = idx_q + 1'b1;
          // The first differing pair (MSB first) decides; later pairs are don't-care.
          if (eq_q) begin
            if (x && !y) begin
              gt_d = 1'b1;
              eq_d = 1'b0;
            end else if (!x && y) begin
              lt_d = 1'b1;
              eq_d = 1'b0;
            end
          end
          if (idx_q == LastIdx) state_d = StFinal;
`ifdef SERIAL_CELL_EARLY_DECIDE_EN
          if (eq_q && (x != y)) state_d = StFinal;
`endif
        end
      end
      StFinal: begin
        unique case ({a_q, b_q})
          2'b00: f_d = eq_q;
          2'b01: f_d = gt_q;
          2'b10: f_d = lt_q;
          2'b11: f_d = gt_q | eq_q;
        endcase
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    bit_ready = (state_q == StRun);
    busy      = (state_q == StInit) || (state_q == StRun);
    idx       = idx_q;
    f         = f_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_serial_cell_der_a_izq.sv
// Self-checking bench for serial_cell_der_a_izq: table-driven operations with a
// scoreboard queue, plus hand-written reset and start-while-busy sequences.
module tb_serial_cell_der_a_izq;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          A = 1'b0;
  logic          B = 1'b0;
  logic          x = 1'b0;
  logic          y = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic          busy;
  logic [CW-1:0] idx;
  logic          f;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] xv;
    logic [7:0] yv;
    logic       tog;
    logic       inj;
    logic       exp_f;
  } vec_t;

  typedef struct {
    int   id;
    logic exp_f;
    int   exp_idx;
    int   exp_lat;
    int   start_cyc;
  } sb_t;

  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t vecs[11];

  serial_cell_der_a_izq #(
    .N (N),
    .CW(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .x        (x),
    .y        (y),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .busy     (busy),
    .idx      (idx),
    .f        (f),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pairs the DUT should consume for given operands.
  function automatic int consumed(input logic [7:0] xv, input logic [7:0] yv);
`ifdef SERIAL_CELL_EARLY_DECIDE_EN
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (xv[i] !== yv[i]) return int'(N) - i;
    end
`endif
    return int'(N);
  endfunction

  // Scoreboard check on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with no operation pending");
      end else begin
        mon_e = sbq.pop_front();
        chk($sformatf("v%0d_f", mon_e.id), 32'(f), 32'(mon_e.exp_f));
        chk($sformatf("v%0d_idx", mon_e.id), 32'(idx), 32'(mon_e.exp_idx));
        chk($sformatf("v%0d_latency", mon_e.id), 32'(cyc - mon_e.start_cyc),
            32'(mon_e.exp_lat));
      end
    end
  end

  task automatic run_op(input int id, input vec_t v);
    int   pos = 0;
    int   c = 0;
    int   nbusy = 0;
    int   nrdy = 0;
    int   k;
    logic pv = 1'b0;
    logic pr = 1'b0;
    sb_t  e;
    k = consumed(v.xv, v.yv);
    @(negedge clk);
    start = 1'b1;
    A = v.a;
    B = v.b;
    bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    e.id = id;
    e.exp_f = v.exp_f;
    e.exp_idx = k;
    e.exp_lat = v.tog ? 2 * k + 2 : k + 2;
    e.start_cyc = cyc;
    sbq.push_back(e);
    while (done !== 1'b1 && c < 100) begin
      if (pv && pr) pos++;
      if (busy === 1'b1) nbusy++;
      if (bit_ready === 1'b1) nrdy++;
      pv = v.tog ? (c % 2 == 0) : 1'b1;
      bit_valid = pv;
      x = (pos < int'(N)) ? v.xv[int'(N) - 1 - pos] : 1'b0;
      y = (pos < int'(N)) ? v.yv[int'(N) - 1 - pos] : 1'b0;
      pr = bit_ready;
      // A second start with inverted select lands while the DUT is in RUN.
      if (v.inj && c == 1) begin
        start = 1'b1;
        A = ~v.a;
        B = ~v.b;
      end else begin
        start = 1'b0;
      end
      c++;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    start = 1'b0;
    chk($sformatf("v%0d_done_seen", id), 32'(done), 32'd1);
    chk($sformatf("v%0d_transfers", id), 32'(pos), 32'(k));
    chk($sformatf("v%0d_busy_cycles", id), 32'(nbusy), 32'(e.exp_lat - 1));
    chk($sformatf("v%0d_ready_cycles", id), 32'(nrdy), 32'(e.exp_lat - 2));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", id), 32'(done), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bit_ready"}, 32'(bit_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idx"}, 32'(idx), 32'd0);
    chk({tag, "_f"}, 32'(f), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h3C, 8'h3D, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h3C, 8'h3D, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h12, 8'h12, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h12, 8'h12, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_op(i, vecs[i]);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1;
    A = 1'b0;
    B = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b1;
    x = 1'b0;
    y = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_bit_ready", 32'(bit_ready), 32'd1);
    chk("pre_reset_f", 32'(f), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    bit_valid = 1'b0;
    rst_n = 1'b1;
    run_op(11, '{1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1});

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
